alu_req_sched: RTL and testbench

- Round-robin scheduler that shares the single 8-bit ALU (6-bit func, operands a/b, result res) between NREQ requesters.
- Each requester posts func/a/b with a valid/ready handshake.
- The scheduler registers the winning operation and drives the ALU. It captures res, then returns the result to the granted requester with a one-cycle response pulse.
- It sits between the control units that need arithmetic and the shared ALU instance.

---
 rtl/alu_req_sched.sv | 126 ++++++++++++
 tb/tb_alu_req_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_req_sched.sv
// alu_req_sched: round-robin arbiter sharing one 8-bit ALU among NREQ requesters
module alu_req_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [6*NREQ-1:0] req_func_i,
  input  logic [8*NREQ-1:0] req_a_i,
  input  logic [8*NREQ-1:0] req_b_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [5:0]        alu_func_o,
  output logic [7:0]        alu_a_o,
  output logic [7:0]        alu_b_o,
  input  logic [7:0]        alu_res_i,
  output logic [NREQ-1:0]   rsp_valid_o,
  output logic [7:0]        rsp_res_o,
  output logic              rsp_err_o,
  output logic [IDW-1:0]    rsp_id_o,
  output logic              busy_o,
  output logic [15:0]       op_count_o
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  state_e          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d, gnt_q, gnt_d, rsp_id_q, rsp_id_d, pick;
  logic [NREQ-1:0] req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [5:0]      alu_func_q, alu_func_d, sel_func;
  logic [7:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d, sel_a, sel_b, rsp_res_q, rsp_res_d;
  logic            rsp_err_q, rsp_err_d, found, bad;
  logic [15:0]     op_count_q, op_count_d;
  // first valid requester searching upward from last+1, wrapping
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    sel_func = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int k = 1; k <= NREQ; k++)
      for (int i = 0; i < NREQ; i++)
        if (!found && req_valid_i[i] && i == (int'(last_q) + k) % NREQ) begin
          found    = 1'b1;
          pick     = IDW'(i);
          sel_func = req_func_i[6*i +: 6];
          sel_a    = req_a_i[8*i +: 8];
          sel_b    = req_b_i[8*i +: 8];
        end
  end
  assign bad = !(alu_func_q inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    alu_func_d  = alu_func_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_res_d   = rsp_res_q;
    rsp_err_d   = rsp_err_q;
    rsp_id_d    = rsp_id_q;
    op_count_d  = op_count_q;
    case (state_q)
      IDLE: if (found) begin
        state_d     = EXEC;
        last_d      = pick;
        gnt_d       = pick;
        alu_func_d  = sel_func;
        alu_a_d     = sel_a;
        alu_b_d     = sel_b;
        req_ready_d = NREQ'(1) << pick;
      end
      EXEC: begin
        state_d     = DONE;
        rsp_err_d   = bad;
        rsp_res_d   = bad ? 8'h00 : alu_res_i;
        rsp_valid_d = NREQ'(1) << gnt_q;
        rsp_id_d    = gnt_q;
      end
      DONE: begin
        state_d    = IDLE;
        op_count_d = op_count_q + 16'(op_count_q != 16'hFFFF);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      gnt_q       <= '0;
      alu_func_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_res_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      alu_func_q  <= alu_func_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_err_q   <= rsp_err_d;
      rsp_id_q    <= rsp_id_d;
      op_count_q  <= op_count_d;
    end
  end
  assign req_ready_o = req_ready_q;
  assign alu_func_o  = alu_func_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_res_o   = rsp_res_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_id_o    = rsp_id_q;
  assign busy_o      = state_q != IDLE;
  assign op_count_o  = op_count_q;
endmodule

// File: tb/tb_alu_req_sched.sv
// tb_alu_req_sched: directed stimulus with a response scoreboard for alu_req_sched
module tb_alu_req_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 3;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [6*NREQ-1:0] req_func = '0;
  logic [8*NREQ-1:0] req_a = '0;
  logic [8*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready, rsp_valid;
  logic [5:0]        alu_func;
  logic [7:0]        alu_a, alu_b, alu_res, rsp_res;
  logic              rsp_err, busy;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       op_count;
  typedef struct {int id; logic [7:0] res; logic err;} exp_t;
  exp_t exq[$];
  int n_checks = 0;
  int n_fail = 0;

  alu_req_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_func_i(req_func),
    .req_a_i(req_a), .req_b_i(req_b), .req_ready_o(req_ready), .alu_func_o(alu_func),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_res_i(alu_res), .rsp_valid_o(rsp_valid),
    .rsp_res_o(rsp_res), .rsp_err_o(rsp_err), .rsp_id_o(rsp_id), .busy_o(busy),
    .op_count_o(op_count)
  );

  always #5 clk = ~clk;

  // reference ALU; unsupported codes return a non-zero pattern so masking is visible
  always_comb begin
    case (alu_func)
      6'b100000: alu_res = alu_a + alu_b;
      6'b100010: alu_res = alu_a - alu_b;
      6'b100100: alu_res = alu_a & alu_b;
      6'b100101: alu_res = alu_a | alu_b;
      6'b101010: alu_res = {7'b0, $signed(alu_a) < $signed(alu_b)};
      default:   alu_res = 8'hAA;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rsp_valid != 0) begin
      if (exq.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
      else begin
        exp_t e;
        e = exq.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
        chk("rsp_res", 32'(rsp_res), 32'(e.res));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
      end
    end
  end

  task automatic set_req(input int i, input logic [5:0] f, input logic [7:0] a, input logic [7:0] b);
    req_func[6*i +: 6] = f;
    req_a[8*i +: 8]    = a;
    req_b[8*i +: 8]    = b;
    req_valid[i]       = 1'b1;
  endtask

  // called at a negedge with the scheduler idle; returns at a negedge in IDLE
  task automatic issue(input int i, input logic [5:0] f, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic ee, input logic [15:0] ecnt);
    exq.push_back('{i, er, ee});
    set_req(i, f, a, b);
    @(posedge clk);
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(1) << i);
    chk("alu_func", 32'(alu_func), 32'(f));
    chk("alu_a", 32'(alu_a), 32'(a));
    chk("alu_b", 32'(alu_b), 32'(b));
    chk("busy_exec", 32'(busy), 32'h1);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'h0);
    chk("op_count", 32'(op_count), 32'(ecnt));
    chk("alu_a_hold", 32'(alu_a), 32'(a));
  endtask

  task automatic chk_reset_outs();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_res", 32'(rsp_res), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_alu", {8'h0, 2'b0, alu_func, alu_a, alu_b}, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_op_count", 32'(op_count), 0);
  endtask

  initial begin
    int ng, last_cyc, idle_cnt;
    repeat (2) @(negedge clk);
    chk_reset_outs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    issue(0, 6'b100000, 8'h12, 8'h34, 8'h46, 1'b0, 16'd1);
    issue(2, 6'b100000, 8'hFF, 8'h02, 8'h01, 1'b0, 16'd2);
    issue(1, 6'b111111, 8'h55, 8'h0F, 8'h00, 1'b1, 16'd3);
    issue(1, 6'b100010, 8'h05, 8'h09, 8'hFC, 1'b0, 16'd4);
    issue(3, 6'b100100, 8'hF0, 8'h3C, 8'h30, 1'b0, 16'd5);
    issue(0, 6'b101010, 8'hFE, 8'h01, 8'h01, 1'b0, 16'd6);
    // all four requesting continuously out of reset
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 6'b100000, 8'(i), 8'h10);
    for (int k = 0; k < 5; k++) exq.push_back('{k % NREQ, 8'(8'h10 + k % NREQ), 1'b0});
    @(posedge clk);
    #1 rst_n = 1'b1;
    ng = 0; last_cyc = 0; idle_cnt = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        chk("rr_grant", 32'(req_ready), 32'(1) << (ng % NREQ));
        if (ng > 0) chk("rr_spacing", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        ng++;
        if (ng == 5) begin
          @(posedge clk);
          #1 req_valid = '0;
          break;
        end
      end else if (ng > 0 && !busy) idle_cnt++;
    end
    chk("rr_grants", 32'(ng), 32'd5);
    chk("rr_idle_gaps", 32'(idle_cnt), 32'd4);
    repeat (2) @(negedge clk);
    chk("rr_op_count", 32'(op_count), 32'd5);
    chk("rr_busy", 32'(busy), 32'h0);
    // reset while requester 3's op is executing
    set_req(3, 6'b100000, 8'h01, 8'h01);
    @(posedge clk);
    @(negedge clk);
    chk("r5_ready", 32'(req_ready), 32'h8);
    rst_n = 1'b0;
    #1 chk_reset_outs();
    set_req(0, 6'b100000, 8'h20, 8'h22);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exq.push_back('{0, 8'h42, 1'b0});
    exq.push_back('{3, 8'h02, 1'b0});
    @(posedge clk);
    @(negedge clk);
    chk("r5_first_grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("r5_second_grant", 32'(req_ready), 32'h8);
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    repeat (2) @(negedge clk);
    chk("r5_op_count", 32'(op_count), 32'd2);
    // counter saturation
    force dut.op_count_q = 16'hFFFD;
    @(posedge clk);
    #1 release dut.op_count_q;
    @(negedge clk);
    chk("sat_preload", 32'(op_count), 32'hFFFD);
    issue(2, 6'b100101, 8'h81, 8'h18, 8'h99, 1'b0, 16'hFFFE);
    issue(3, 6'b100000, 8'h80, 8'h80, 8'h00, 1'b0, 16'hFFFF);
    issue(0, 6'b000000, 8'h01, 8'h02, 8'h00, 1'b1, 16'hFFFF);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
